latch_write_sched: RTL
======================

# latch_write_sched

Round-robin write scheduler for a shared bank of level-sensitive latches with asynchronous clear. It arbitrates NREQ requesters and presents one write at a time on the shared latch d/gate inputs. Each write follows the sequence data-setup, gate pulse, then data-hold, so d never changes while the gate is open. Latch clear requests are also serialised here. The block sits between the requesting logic and the latch bank, and it is the only driver of the latch bank's d, clock and reset inputs.

## Interface
- NREQ, 4: number of requesters; must be at least 2.
- WIDTH, 8: latch data width.
- GATE_CYCLES, 2: number of cycles the latch gate is held high; must be at least 1.

- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset; asynchronous assertion, active-low; one clock, reset is asynchronous and active-low.
- req  in  NREQ  per-requester write request; level; held until the matching done.
- req_data  in  NREQ*WIDTH  write data; slice i = req_data[i*WIDTH +: WIDTH]; sampled only at grant.
- clr_req  in  1  single-cycle pulse requesting a latch-bank clear.
- grant  out  NREQ  one-hot; owner of the transaction in progress.
- done  out  NREQ  one-hot single-cycle pulse; marks the HOLD cycle of the owner's write.
- latch_d  out  WIDTH  registered data to the latch bank d input.
- latch_clock  out  1  latch gate; high means transparent.
- latch_reset  out  1  latch-bank clear; active-high.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, SETUP, GATE, HOLD.
- IDLE, pending clear set: go to CLEAR. Clear has priority over every req.
- IDLE, otherwise, any req high: pick the winner by round-robin.
  - Search starts at ptr and wraps NREQ-1 to 0.
  - On the transition edge: set grant[winner], load latch_d with req_data slice of the winner, go to SETUP.
- SETUP: 1 cycle; latch_clock=0; then go to GATE and load gcnt=GATE_CYCLES-1.
- GATE: latch_clock=1; latch_d stable. If gcnt==0 go to HOLD, else decrement gcnt.
- HOLD: 1 cycle; latch_clock=0; latch_d stable; done[winner]=1.
  - Then go to IDLE, clear grant, set ptr=(winner+1) mod NREQ.
- CLEAR: 1 cycle; latch_reset=1; latch_clock=0; clear the pending-clear flag; go to IDLE. latch_d and ptr are unchanged.
- Pending clear flag:
  - Set by clr_req in any state, including CLEAR itself. A pulse arriving in CLEAR re-arms the flag and causes one more clear.
  - Multiple pulses arriving before service collapse into a single clear.
- Dropping req mid-transaction does not abort. The write completes and done still pulses.
- req_data changes after grant are ignored.
- A requester that keeps req high after its done is re-eligible only after the round-robin pointer passes it.

## Timing
- Reset values (while reset_n low): state=IDLE, grant=0, done=0, latch_d=0, latch_clock=0, busy=0, ptr=0, pending=0.
  - latch_reset=1 while reset_n is low (combinational OR with ~reset_n), so the downstream latch clears asynchronously.
- All outputs are registered except latch_reset, which is the OR of the CLEAR-state register and ~reset_n.
- Write latency: req sampled high at edge k.
  - SETUP during cycle k.
  - GATE during cycles k+1 .. k+GATE_CYCLES.
  - HOLD/done at k+GATE_CYCLES+1.
  - IDLE at k+GATE_CYCLES+2.
- Back-to-back writes: one write per GATE_CYCLES+3 cycles.
- A clear occupies 2 cycles (CLEAR plus IDLE).
- Relative to latch_clock: latch_d is stable at least 1 cycle before it rises and at least 1 cycle after it falls.
- Reset mid-operation: immediate return to reset values. latch_clock drops asynchronously; no done is issued.

## Test plan
- Single write: NREQ=4, GATE_CYCLES=2, req[2]=1 with data 0xA5.
  - Required: grant=4'b0100; latch_d=0xA5 one cycle before latch_clock; latch_clock high exactly 2 cycles; done[2] one cycle later; ptr=3.
- Fairness: req=4'b1111 held continuously.
  - Required: grant order 0,1,2,3,0; each grant 5 cycles apart; never two grant bits set.
- Contention after wrap: ptr=3, req=4'b1001 simultaneous.
  - Required: requester 3 first, then 0.
- Clear during write: clr_req pulsed twice during GATE of requester 1.
  - Required: the write completes with done[1]; exactly one CLEAR cycle (latch_reset=1) follows, before the next grant; latch_d is held.
- Reset mid-GATE: reset_n low for 3 cycles.
  - Required: latch_clock=0 and latch_reset=1 immediately; all outputs at reset values; no done.
  - After release: arbitration restarts from requester 0.
- GATE_CYCLES=1: check a single-cycle gate pulse and 4-cycle back-to-back spacing.

Source files
------------

// File: rtl/latch_write_sched.sv
// Round-robin write scheduler for a shared level-sensitive latch bank.
// Each write is sequenced as data setup, gate pulse, data hold; clears are serialised.
module latch_write_sched #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int GATE_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic                    clr_req,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        latch_d,
    output logic                    latch_clock,
    output logic                    latch_reset,
    output logic                    busy
);

    localparam int PW = $clog2(NREQ);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, SETUP, GATE, HOLD} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     ptr, ptr_nx, owner, owner_nx, win;
    logic              win_vld;
    logic [GW-1:0]     gcnt, gcnt_nx;
    logic              pending, pending_nx;
    logic              clr_q, clr_nx;
    logic [NREQ-1:0]   grant_nx, done_nx;
    logic [WIDTH-1:0]  d_nx;
    logic              lc_nx, busy_nx;

    // Round-robin search from ptr; scanning downward leaves the closest hit.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_vld = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                win     = PW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        owner_nx   = owner;
        gcnt_nx    = gcnt;
        grant_nx   = grant;
        d_nx       = latch_d;
        pending_nx = pending | clr_req;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nx = CLEAR;
                end else if (win_vld) begin
                    state_nx      = SETUP;
                    owner_nx      = win;
                    grant_nx      = '0;
                    grant_nx[win] = 1'b1;
                    d_nx          = req_data[int'(win)*WIDTH +: WIDTH];
                end
            end
            CLEAR: begin
                // A pulse landing in CLEAR re-arms for one more clear.
                pending_nx = clr_req;
                state_nx   = IDLE;
            end
            SETUP: begin
                state_nx = GATE;
                gcnt_nx  = GW'(GATE_CYCLES - 1);
            end
            GATE: begin
                if (gcnt == '0) state_nx = HOLD;
                else            gcnt_nx  = gcnt - 1'b1;
            end
            HOLD: begin
                state_nx = IDLE;
                grant_nx = '0;
                ptr_nx   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Outputs are flopped from the next state so the gate is glitch-free.
        lc_nx   = (state_nx == GATE);
        busy_nx = (state_nx != IDLE);
        clr_nx  = (state_nx == CLEAR);
        done_nx = (state_nx == HOLD) ? grant_nx : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            gcnt        <= '0;
            pending     <= 1'b0;
            clr_q       <= 1'b0;
            grant       <= '0;
            done        <= '0;
            latch_d     <= '0;
            latch_clock <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            gcnt        <= gcnt_nx;
            pending     <= pending_nx;
            clr_q       <= clr_nx;
            grant       <= grant_nx;
            done        <= done_nx;
            latch_d     <= d_nx;
            latch_clock <= lc_nx;
            busy        <= busy_nx;
        end
    end

    // Reset reaches the latch bank without waiting for a clock.
    assign latch_reset = clr_q | ~reset_n;

endmodule
